// File: rtl/ffe_ctrl_param.sv
// Tap sequencer for the FFE datapath: accepts samples, walks NUM_TAPS (or fewer) MAC cycles, flags overruns.
// Optional macro FFE_CTRL_OVR_CNT_EN adds the saturating 8-bit dropped-sample counter ovr_cnt.
module ffe_ctrl_param #(
    parameter int NUM_TAPS  = 4,
    parameter int ADDR_SIZE = $clog2(NUM_TAPS),
    parameter int TAPS_W    = ADDR_SIZE + 1
) (
    input  logic                 ffe_clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [TAPS_W-1:0]    cfg_taps,
    input  logic                 ovr_clr,
    output logic                 shift_en,
    output logic                 rd_en,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 acc_clr,
    output logic                 out_vld,
    output logic                 busy,
`ifdef FFE_CTRL_OVR_CNT_EN
    output logic [7:0]           ovr_cnt,
`endif
    output logic                 ovr
);

    localparam logic [TAPS_W-1:0] MAX_TAPS = TAPS_W'(NUM_TAPS);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPUTE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TAPS_W-1:0] k_q, k_d;
    logic [TAPS_W-1:0] n_reg_q, n_reg_d;
    logic              out_vld_q, out_vld_d;
    logic              ovr_q, ovr_d;

    logic [TAPS_W-1:0] n_eff;
    logic [TAPS_W-1:0] n_last;
    logic              legal;
    logic              drop;

    always_comb begin
        n_eff = cfg_taps;
        if (cfg_taps == '0 || cfg_taps > MAX_TAPS) begin
            n_eff = MAX_TAPS;
        end
    end

    // A corrupted N_reg or k beyond the period is treated as illegal and flushed to IDLE.
    assign n_last = n_reg_q - TAPS_W'(1);
    assign legal  = (n_reg_q != '0) && (n_reg_q <= MAX_TAPS) && (k_q < n_reg_q);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_reg_d   = n_reg_q;
        out_vld_d = 1'b0;
        in_rdy    = 1'b0;
        shift_en  = 1'b0;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        busy      = 1'b0;
        rd_addr   = '0;
        case (state_q)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    state_d = S_COMPUTE;
                    k_d     = '0;
                    n_reg_d = n_eff;
                end
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (!legal) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    n_reg_d = MAX_TAPS;
                end else begin
                    rd_en    = 1'b1;
                    rd_addr  = ADDR_SIZE'(n_last - k_q);
                    shift_en = (k_q == '0);
                    acc_clr  = (k_q == '0);
                    if (k_q == n_last) begin
                        in_rdy    = 1'b1;
                        out_vld_d = 1'b1;
                        k_d       = '0;
                        if (in_vld) begin
                            n_reg_d = n_eff;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        k_d = k_q + TAPS_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Set has priority over clear so a drop in the clearing cycle is never lost.
    assign drop  = in_vld & ~in_rdy;
    assign ovr_d = drop | (ovr_q & ~ovr_clr);

    always_ff @(posedge ffe_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            n_reg_q   <= MAX_TAPS;
            out_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_reg_q   <= n_reg_d;
            out_vld_q <= out_vld_d;
            ovr_q     <= ovr_d;
        end
    end

    assign out_vld = out_vld_q;
    assign ovr     = ovr_q;

`ifdef FFE_CTRL_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (ovr_clr) begin
            ovr_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && ovr_cnt_q != 8'hFF) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge ffe_clk) begin
        if (rst) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_ffe_ctrl_param.sv
// Directed bench for ffe_ctrl_param (NUM_TAPS=4): vector table plus reset, mid-period reset and counter sequences.
module tb_ffe_ctrl_param;

    localparam int NUM_TAPS  = 4;
    localparam int ADDR_SIZE = 2;
    localparam int TAPS_W    = 3;

    logic                 ffe_clk = 1'b0;
    logic                 rst;
    logic                 in_vld;
    logic                 in_rdy;
    logic [TAPS_W-1:0]    cfg_taps;
    logic                 ovr_clr;
    logic                 shift_en;
    logic                 rd_en;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 acc_clr;
    logic                 out_vld;
    logic                 busy;
    logic                 ovr;
`ifdef FFE_CTRL_OVR_CNT_EN
    logic [7:0]           ovr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ffe_ctrl_param #(.NUM_TAPS(NUM_TAPS)) dut (
        .ffe_clk (ffe_clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .cfg_taps(cfg_taps),
        .ovr_clr (ovr_clr),
        .shift_en(shift_en),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .acc_clr (acc_clr),
        .out_vld (out_vld),
        .busy    (busy),
`ifdef FFE_CTRL_OVR_CNT_EN
        .ovr_cnt (ovr_cnt),
`endif
        .ovr     (ovr)
    );

    always #5 ffe_clk = ~ffe_clk;

    typedef struct {
        logic              vld;
        logic [TAPS_W-1:0] taps;
        logic              clr;
        logic [8:0]        exp;
    } vec_t;

    vec_t tbl[$];

    // Packed view: {in_rdy, shift_en, rd_en, rd_addr[1:0], acc_clr, out_vld, busy, ovr}
    function automatic logic [8:0] pack_out();
        return {in_rdy, shift_en, rd_en, rd_addr, acc_clr, out_vld, busy, ovr};
    endfunction

    task automatic add(input logic vld, input int taps, input logic clr,
                       input logic rdy, input logic sh, input logic rd, input int addr,
                       input logic acc, input logic ov, input logic bsy, input logic ovf);
        vec_t v;
        v.vld  = vld;
        v.taps = TAPS_W'(taps);
        v.clr  = clr;
        v.exp  = {rdy, sh, rd, 2'(addr), acc, ov, bsy, ovf};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge ffe_clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_vld   = 1'b1;
        cfg_taps = 3'd4;
        ovr_clr  = 1'b0;

        // Reset held 3 cycles with in_vld high: no strobes may appear
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i > 0) begin
                chk($sformatf("reset_strobes_%0d", i),
                    {26'd0, shift_en, rd_en, acc_clr, out_vld, busy, ovr}, 32'd0);
                chk($sformatf("reset_addr_%0d", i), {30'd0, rd_addr}, 32'd0);
            end
        end
        rst    = 1'b0;
        in_vld = 1'b0;
        chk("post_reset_rdy_busy", {30'd0, in_rdy, busy}, 32'b10);

        add(1,4,0, 1,0,0,0,0,0,0,0);
        add(0,4,0, 0,1,1,3,1,0,1,0);
        add(0,4,0, 0,0,1,2,0,0,1,0);
        add(0,4,0, 0,0,1,1,0,0,1,0);
        add(0,4,0, 1,0,1,0,0,0,1,0);
        add(0,4,0, 1,0,0,0,0,1,0,0);
        add(1,4,0, 1,0,0,0,0,0,0,0);
        add(0,4,0, 0,1,1,3,1,0,1,0);
        add(0,4,0, 0,0,1,2,0,0,1,0);
        add(0,4,0, 0,0,1,1,0,0,1,0);
        add(1,2,0, 1,0,1,0,0,0,1,0);
        add(0,2,0, 0,1,1,1,1,1,1,0);
        add(1,0,0, 1,0,1,0,0,0,1,0);
        add(0,0,0, 0,1,1,3,1,1,1,0);
        add(0,0,0, 0,0,1,2,0,0,1,0);
        add(0,0,0, 0,0,1,1,0,0,1,0);
        add(1,7,0, 1,0,1,0,0,0,1,0);
        add(0,7,0, 0,1,1,3,1,1,1,0);
        add(0,7,0, 0,0,1,2,0,0,1,0);
        add(0,7,0, 0,0,1,1,0,0,1,0);
        add(1,1,0, 1,0,1,0,0,0,1,0);
        add(1,1,0, 1,1,1,0,1,1,1,0);
        add(1,1,0, 1,1,1,0,1,1,1,0);
        add(0,1,0, 1,1,1,0,1,1,1,0);
        add(0,1,0, 1,0,0,0,0,1,0,0);
        add(1,4,0, 1,0,0,0,0,0,0,0);
        add(0,4,0, 0,1,1,3,1,0,1,0);
        add(1,4,0, 0,0,1,2,0,0,1,0);
        add(0,4,0, 0,0,1,1,0,0,1,1);
        add(0,4,0, 1,0,1,0,0,0,1,1);
        add(0,4,1, 1,0,0,0,0,1,0,1);
        add(0,4,0, 1,0,0,0,0,0,0,0);
        add(1,2,0, 1,0,0,0,0,0,0,0);
        add(1,2,1, 0,1,1,1,1,0,1,0);
        add(0,2,0, 1,0,1,0,0,0,1,1);
        add(0,2,1, 1,0,0,0,0,1,0,1);
        add(0,2,0, 1,0,0,0,0,0,0,0);

        foreach (tbl[i]) begin
            in_vld   = tbl[i].vld;
            cfg_taps = tbl[i].taps;
            ovr_clr  = tbl[i].clr;
            chk($sformatf("vec_%0d rdy,sh,rd,addr,acc,ov,busy,ovr", i), {23'd0, pack_out()}, {23'd0, tbl[i].exp});
            tick();
        end
        in_vld  = 1'b0;
        ovr_clr = 1'b0;

        // Mid-period reset with an overrun pending: period abandoned, ovr cleared
        cfg_taps = 3'd4;
        in_vld   = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("midrst_k2_addr", {30'd0, rd_addr}, 32'd1);
        chk("midrst_k2_ovr", {31'd0, ovr}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_idle", {23'd0, pack_out()}, {23'd0, 9'b100000000});
        tick();
        chk("midrst_no_outvld_1", {31'd0, out_vld}, 32'd0);
        tick();
        chk("midrst_no_outvld_2", {31'd0, out_vld}, 32'd0);
        cfg_taps = 3'd3;
        in_vld   = 1'b1;
        tick();
        in_vld = 1'b0;
        chk("midrst_restart_k0", {29'd0, shift_en, rd_addr}, {29'd0, 1'b1, 2'd2});
        tick();
        chk("midrst_restart_k1", {30'd0, rd_addr}, 32'd1);
        tick();
        chk("midrst_restart_k2", {30'd0, rd_addr}, 32'd0);
        tick();
        chk("midrst_restart_outvld", {30'd0, out_vld, busy}, 32'b10);

`ifdef FFE_CTRL_OVR_CNT_EN
        begin
            int drops = 0;
            bit waited = 0;
            ovr_clr = 1'b1;
            tick();
            ovr_clr = 1'b0;
            chk("cnt_cleared", {24'd0, ovr_cnt}, 32'd0);
            cfg_taps = 3'd4;
            in_vld   = 1'b1;
            for (int c = 0; c < 2000 && drops < 300; c++) begin
                if (!in_rdy) drops++;
                tick();
            end
            chk("cnt_drops_reached", drops, 300);
            chk("cnt_saturated", {24'd0, ovr_cnt}, 32'd255);
            for (int c = 0; c < 10 && !waited; c++) begin
                if (!in_rdy) waited = 1;
                else tick();
            end
            chk("cnt_found_busy_cycle", {31'd0, waited}, 32'd1);
            ovr_clr = 1'b1;
            tick();
            ovr_clr = 1'b0;
            in_vld  = 1'b0;
            chk("cnt_clr_with_drop", {24'd0, ovr_cnt}, 32'd1);
            for (int c = 0; c < 6; c++) tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
